// File: rtl/rle_pkg.sv
// Shared types and constants for the RLE decoder: FSM states, pair field
// offsets and the word geometry used by the byte packer.
package rle_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_EXPAND,
        S_WRITE,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam int COUNT_LSB  = 0;
    localparam int VALUE_LSB  = 8;
    localparam int PAIR_W     = 16;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = 32;

    // Compressed bytes consumed by one word read: a short tail is only 2 bytes.
    function automatic logic [31:0] take_bytes(input logic [31:0] remaining);
        return (remaining >= 32'(WORD_BYTES)) ? 32'(WORD_BYTES) : remaining;
    endfunction

endpackage

// File: rtl/rle_decode_if.sv
// Single-port SRAM port A as seen by the decoder (master) and memory (slave).
interface rle_decode_if
    import rle_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic              port_A_clk;
    logic [ADDR_W-1:0] port_A_addr;
    logic              port_A_we;
    logic [WORD_W-1:0] port_A_data_in;
    logic [WORD_W-1:0] port_A_data_out;

    modport master (
        output port_A_clk,
        output port_A_addr,
        output port_A_we,
        output port_A_data_in,
        input  port_A_data_out
    );

    modport slave (
        input  port_A_clk,
        input  port_A_addr,
        input  port_A_we,
        input  port_A_data_in,
        output port_A_data_out
    );
endinterface

// File: rtl/rle_byte_packer.sv
// Four-lane byte packer: bytes fill lanes from bits [7:0] upward; the word
// output always shows unfilled lanes as zero so a partial word can be flushed.
module rle_byte_packer
    import rle_pkg::*;
(
    input  logic              clk,
    input  logic              nreset,
    input  logic              clear,
    input  logic              push,
    input  logic [7:0]        byte_in,
    output logic [2:0]        lane_cnt,
    output logic              full,
    output logic [WORD_W-1:0] word
);
    logic [WORD_BYTES-1:0][7:0] lanes;

    assign full = (lane_cnt == 3'(WORD_BYTES));
    assign word = lanes;

    // NOTE: the lanes are reset too, not just the count: they drive SRAM write
    // data directly, which has to read zero out of reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lanes    <= '0;
            lane_cnt <= '0;
        end else if (clear) begin
            lanes    <= '0;
            lane_cnt <= '0;
        end else if (push && !full) begin
            lanes[lane_cnt[1:0]] <= byte_in;
            lane_cnt             <= lane_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/rle_decode.sv
// RLE frame decoder over one SRAM port. Define RLE_DEC_LIMIT_EN to add the
// msg_max output-length bound and the overflow flag.
module rle_decode
    import rle_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [31:0] rle_addr,
    input  logic [31:0] rle_size,
    input  logic [31:0] msg_addr,
    output logic [31:0] msg_size,
    output logic        done,
`ifdef RLE_DEC_LIMIT_EN
    input  logic [31:0] msg_max,
    output logic        overflow,
`endif
    rle_decode_if.master mem
);
    state_t            state;
    logic [31:0]       rd_ptr;
    logic [31:0]       wr_ptr;
    logic [31:0]       remaining;
    logic [7:0]        run_cnt;
    logic [7:0]        run_val;
    logic [PAIR_W-1:0] hi_pair;
    logic              hi_pending;
    logic              we_q;

    logic              pk_clear;
    logic              pk_push;
    logic              pk_full;
    logic [2:0]        pk_cnt;
    logic [WORD_W-1:0] pk_word;
    logic              limit_hit;

`ifdef RLE_DEC_LIMIT_EN
    logic work_left;
    assign limit_hit = ((msg_size + {29'd0, pk_cnt}) == msg_max);
    assign work_left = (run_cnt != 8'd0) || hi_pending || (remaining != 32'd0);
`else
    assign limit_hit = 1'b0;
`endif

    assign pk_push  = (state == S_EXPAND) && !limit_hit && (run_cnt != 8'd0) && !pk_full;
    assign pk_clear = (state == S_WRITE) || (state == S_FLUSH) || ((state == S_IDLE) && start);

    rle_byte_packer u_packer (
        .clk      (clk),
        .nreset   (nreset),
        .clear    (pk_clear),
        .push     (pk_push),
        .byte_in  (run_val),
        .lane_cnt (pk_cnt),
        .full     (pk_full),
        .word     (pk_word)
    );

    assign mem.port_A_clk     = clk;
    assign mem.port_A_we      = we_q;
    assign mem.port_A_addr    = we_q ? wr_ptr[ADDR_W-1:0] : rd_ptr[ADDR_W-1:0];
    assign mem.port_A_data_in = pk_word;

    // NOTE: all state here is updated with non-blocking assignments, so every
    // branch below reads the values from before this clock edge.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= S_IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            remaining  <= '0;
            msg_size   <= '0;
            run_cnt    <= '0;
            run_val    <= '0;
            hi_pair    <= '0;
            hi_pending <= 1'b0;
            we_q       <= 1'b0;
            done       <= 1'b1;
`ifdef RLE_DEC_LIMIT_EN
            overflow   <= 1'b0;
`endif
        end else begin
            we_q <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rd_ptr     <= rle_addr;
                        wr_ptr     <= msg_addr;
                        remaining  <= rle_size;
                        msg_size   <= '0;
                        run_cnt    <= '0;
                        hi_pending <= 1'b0;
`ifdef RLE_DEC_LIMIT_EN
                        overflow   <= 1'b0;
`endif
                        state      <= (rle_size == 32'd0) ? S_DONE : S_READ;
                    end else begin
                        done <= 1'b1;
                    end
                end
                S_READ: state <= S_LATCH;
                S_LATCH: begin
                    run_cnt    <= mem.port_A_data_out[COUNT_LSB +: 8];
                    run_val    <= mem.port_A_data_out[VALUE_LSB +: 8];
                    hi_pair    <= mem.port_A_data_out[WORD_W-1 -: PAIR_W];
                    hi_pending <= (remaining >= 32'(WORD_BYTES));
                    rd_ptr     <= rd_ptr + 32'(WORD_BYTES);
                    remaining  <= remaining - take_bytes(remaining);
                    state      <= S_EXPAND;
                end
                S_EXPAND: begin
`ifdef RLE_DEC_LIMIT_EN
                    if (limit_hit) begin
                        overflow <= work_left;
                        if (pk_cnt != 3'd0) begin
                            state <= S_FLUSH;
                            we_q  <= 1'b1;
                        end else begin
                            state <= S_DONE;
                        end
                    end else
`endif
                    if (run_cnt == 8'd0) begin
                        // Current pair exhausted (or had count 0): advance.
                        if (hi_pending) begin
                            run_cnt    <= hi_pair[COUNT_LSB +: 8];
                            run_val    <= hi_pair[VALUE_LSB +: 8];
                            hi_pending <= 1'b0;
                        end else if (remaining != 32'd0) begin
                            state <= S_READ;
                        end else if (pk_cnt != 3'd0) begin
                            state <= S_FLUSH;
                            we_q  <= 1'b1;
                        end else begin
                            state <= S_DONE;
                        end
                    end else begin
                        run_cnt <= run_cnt - 8'd1;
                        if (pk_cnt == 3'(WORD_BYTES - 1)) begin
                            state <= S_WRITE;
                            we_q  <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    wr_ptr   <= wr_ptr + 32'(WORD_BYTES);
                    msg_size <= msg_size + 32'(WORD_BYTES);
                    state    <= S_EXPAND;
                end
                S_FLUSH: begin
                    wr_ptr   <= wr_ptr + 32'(WORD_BYTES);
                    msg_size <= msg_size + {29'd0, pk_cnt};
                    state    <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
